// File: rtl/spi_master_core.sv
// SPI master for one 8-bit transfer per start request, with per-transfer CPOL/CPHA
// and an SCLK half-period of D ACLK cycles; completion is reported through a sticky flag.
module spi_master_core #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic [31:0] control_reg,
  input  logic [7:0]  tx_spi,
  input  logic [31:0] spi_div,
  output logic [7:0]  rx_spi,
  output logic        spi_busy,
  output logic        spi_done,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        cs_n
);

  localparam int unsigned EDGE_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 start_q, start_d;
  logic                 cpol_q, cpol_d;
  logic                 cpha_q, cpha_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [EDGE_W-1:0]    edge_q, edge_d;
  logic [7:0]           tx_sh_q, tx_sh_d;
  logic [7:0]           rx_sh_q, rx_sh_d;
  logic [7:0]           rx_q, rx_d;
  logic                 sclk_q, sclk_d;
  logic                 mosi_q, mosi_d;
  logic                 cs_n_q, cs_n_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 start_c;
  logic [DIV_WIDTH-1:0] div_eff_c;
  logic                 cnt_last_c;
  logic                 lead_c;
  logic                 term_c;
  logic                 sample_c;
  logic                 advance_c;

  // Bits of the shared control/divider registers this block does not use.
  logic unused_ctrl;
  assign unused_ctrl = ^{control_reg[31:4], control_reg[0]};

  if (DIV_WIDTH < 32) begin : g_unused_div
    logic unused_div;
    assign unused_div = ^spi_div[31:DIV_WIDTH];
  end

  assign start_c    = control_reg[1] & ~start_q;
  assign div_eff_c  = (spi_div[DIV_WIDTH-1:0] == '0) ? DIV_WIDTH'(1) : spi_div[DIV_WIDTH-1:0];
  assign cnt_last_c = (cnt_q == (div_q - DIV_WIDTH'(1)));
  // edge_q holds edges already issued, so the edge about to happen is leading when it is even.
  assign lead_c     = ~edge_q[0];
  assign term_c     = (edge_q == EDGE_W'(15));
  assign sample_c   = cpha_q ? ~lead_c : lead_c;
  assign advance_c  = cpha_q ? lead_c : (~lead_c & ~term_c);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      div_q   <= '0;
      cnt_q   <= '0;
      edge_q  <= '0;
      tx_sh_q <= 8'h00;
      rx_sh_q <= 8'h00;
      rx_q    <= 8'h00;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      tx_sh_q <= tx_sh_d;
      rx_sh_q <= rx_sh_d;
      rx_q    <= rx_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    start_d = control_reg[1];
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    edge_d  = edge_q;
    tx_sh_d = tx_sh_q;
    rx_sh_d = rx_sh_q;
    rx_d    = rx_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    busy_d  = busy_q;
    done_d  = done_q;

    unique case (state_q)
      IDLE: begin
        if (start_c) begin
          cpol_d  = control_reg[2];
          cpha_d  = control_reg[3];
          div_d   = div_eff_c;
          cnt_d   = '0;
          edge_d  = '0;
          sclk_d  = control_reg[2];
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          rx_sh_d = 8'h00;
          // CPHA=0 presents bit 7 before the first edge; CPHA=1 waits for the leading edge.
          if (control_reg[3]) begin
            tx_sh_d = tx_spi;
            mosi_d  = 1'b0;
          end else begin
            tx_sh_d = {tx_spi[6:0], 1'b0};
            mosi_d  = tx_spi[7];
          end
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (cnt_last_c) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          edge_d = edge_q + EDGE_W'(1);
          if (sample_c) begin
            rx_sh_d = {rx_sh_q[6:0], miso};
          end
          if (advance_c) begin
            mosi_d  = tx_sh_q[7];
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
          end
          if (term_c) begin
            state_d = HOLD;
          end
        end else begin
          cnt_d = cnt_q + DIV_WIDTH'(1);
        end
      end

      HOLD: begin
        // D cycles of hold with cs_n low, then the completion cycle.
        if (cnt_q == div_q) begin
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          rx_d    = rx_sh_q;
          mosi_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + DIV_WIDTH'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rx_spi   = rx_q;
  assign spi_busy = busy_q;
  assign spi_done = done_q;
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;

endmodule

// File: tb/tb_spi_master_core.sv
// Directed bench for spi_master_core: a slave/monitor watches the SPI pins and a
// scoreboard queue holds the byte each accepted transfer must return.
module tb_spi_master_core;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [31:0] control_reg = 32'h0;
  logic [7:0]  tx_spi = 8'h00;
  logic [31:0] spi_div = 32'd2;
  logic [7:0]  rx_spi;
  logic        spi_busy, spi_done, sclk, mosi, cs_n;
  wire         miso;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Bench model of the transfer in flight
  bit        cpol_tb, cpha_tb, loop_tb;
  logic [7:0] slave_tb, tx_tb, last_rx;
  int        d_tb, s_cyc;
  logic [7:0] exp_q[$];

  // Slave / monitor state
  logic      slave_miso = 1'b0;
  logic      prev_sclk = 1'b0;
  logic      prev_cs_n = 1'b1;
  int        edges_seen = 0;
  int        spacing_err = 0;
  int        last_edge = 0;
  int        sidx = 0;
  int        xfers = 0;
  logic [7:0] cap = 8'h00;

  assign miso = loop_tb ? mosi : slave_miso;

  spi_master_core #(.DIV_WIDTH(16)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .control_reg(control_reg), .tx_spi(tx_spi),
    .spi_div(spi_div), .rx_spi(rx_spi), .spi_busy(spi_busy), .spi_done(spi_done),
    .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  // Sampled-edge slave: captures mosi and drives miso according to the bench's CPOL/CPHA.
  always @(negedge ACLK) begin
    if (!cs_n && prev_cs_n) begin
      edges_seen = 0; spacing_err = 0; sidx = 0; cap = 8'h00;
      last_edge = cyc; xfers = xfers + 1;
      if (!cpha_tb) slave_miso = slave_tb[7];
    end else if (!cs_n && (sclk !== prev_sclk)) begin
      edges_seen = edges_seen + 1;
      if (cyc - last_edge != d_tb) spacing_err = spacing_err + 1;
      last_edge = cyc;
      if (!cpha_tb) begin
        if (sclk !== cpol_tb) cap = {cap[6:0], mosi};
        else if (sidx < 7) begin
          sidx = sidx + 1;
          slave_miso = slave_tb[3'(7 - sidx)];
        end
      end else begin
        if (sclk !== cpol_tb) begin
          if (sidx < 8) slave_miso = slave_tb[3'(7 - sidx)];
          sidx = sidx + 1;
        end else cap = {cap[6:0], mosi};
      end
    end
    prev_sclk = sclk;
    prev_cs_n = cs_n;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_xfer(input int div, input bit cpol, input bit cpha, input logic [7:0] tx,
                            input logic [7:0] slave, input bit loop, input bit keep, input bit rel);
    @(negedge ACLK);
    cpol_tb = cpol; cpha_tb = cpha; loop_tb = loop; slave_tb = slave; tx_tb = tx;
    d_tb = (div == 0) ? 1 : div;
    tx_spi = tx;
    spi_div = 32'(div);
    control_reg = {28'h0, cpha, cpol, 1'b1, 1'b0};
    if (rel) ARESETn = 1'b1;
    exp_q.push_back(loop ? tx : slave);
    @(negedge ACLK);
    s_cyc = cyc;
    check("busy_at_start", spi_busy, 1);
    check("cs_n_at_start", cs_n, 0);
    check("done_cleared", spi_done, 0);
    check("rx_held_at_start", rx_spi, last_rx);
    if (!keep) control_reg[1] = 1'b0;
  endtask

  task automatic finish_xfer(input bit disturb);
    int lim;
    bit got;
    int rx_glitch;
    logic [7:0] exp;
    lim = 17 * d_tb + 20;
    got = 0;
    rx_glitch = 0;
    for (int n = 1; n <= lim; n++) begin
      @(negedge ACLK);
      if (disturb && n == 5) begin
        control_reg[1] = 1'b0;
        control_reg[2] = ~cpol_tb;
        tx_spi = ~tx_tb;
        spi_div = 32'd7;
      end
      if (disturb && n == 6) control_reg[1] = 1'b1;
      if (spi_done) begin
        got = 1;
        break;
      end
      if (rx_spi !== last_rx) rx_glitch++;
    end
    if (!got) begin
      check("done_timeout", spi_done, 1);
    end else begin
      exp = exp_q.pop_front();
      check("latency", cyc - s_cyc, 17 * d_tb + 1);
      check("rx_byte", rx_spi, exp);
      check("cs_n_after", cs_n, 1);
      check("busy_after", spi_busy, 0);
      check("sclk_idle", sclk, cpol_tb);
      check("mosi_idle", mosi, 0);
      check("edge_count", edges_seen, 16);
      check("mosi_bits", cap, tx_tb);
      check("edge_spacing_err", spacing_err, 0);
      check("rx_stable_mid", rx_glitch, 0);
      last_rx = exp;
    end
  endtask

  initial begin
    int xf;
    int busy_seen;
    bit hit;
    last_rx = 8'h00;
    loop_tb = 1'b1;
    d_tb = 2;

    repeat (3) @(negedge ACLK);
    check("rst_sclk", sclk, 0);
    check("rst_cs_n", cs_n, 1);
    check("rst_mosi", mosi, 0);
    check("rst_busy", spi_busy, 0);
    check("rst_done", spi_done, 0);
    check("rst_rx", rx_spi, 8'h00);
    ARESETn = 1'b1;
    @(negedge ACLK);

    // Loopback, mode 0, D=2
    start_xfer(2, 1'b0, 1'b0, 8'hA5, 8'h00, 1'b1, 1'b0, 1'b0);
    finish_xfer(1'b0);

    // Mode 3 against a slave returning 0xC3, D=3
    start_xfer(3, 1'b1, 1'b1, 8'h3C, 8'hC3, 1'b0, 1'b0, 1'b0);
    finish_xfer(1'b0);
    repeat (3) @(negedge ACLK);
    check("sclk_idles_high", sclk, 1);
    check("done_sticky", spi_done, 1);

    // Start held high, re-toggled and registers disturbed mid-transfer
    start_xfer(2, 1'b0, 1'b0, 8'h5A, 8'h00, 1'b1, 1'b1, 1'b0);
    finish_xfer(1'b1);
    xf = xfers;
    busy_seen = 0;
    for (int n = 0; n < 70; n++) begin
      @(negedge ACLK);
      if (spi_busy) busy_seen++;
    end
    check("held_start_busy", busy_seen, 0);
    check("held_start_xfers", xfers, xf);
    check("held_start_done", spi_done, 1);
    control_reg[1] = 1'b0;

    // spi_div = 0 behaves as D = 1
    start_xfer(0, 1'b0, 1'b0, 8'h81, 8'h00, 1'b1, 1'b0, 1'b0);
    finish_xfer(1'b0);

    // Reset after the 7th SCLK edge
    start_xfer(4, 1'b0, 1'b1, 8'h96, 8'h00, 1'b1, 1'b0, 1'b0);
    hit = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge ACLK);
      if (edges_seen >= 7) begin
        hit = 1;
        break;
      end
    end
    if (!hit) check("edge7_timeout", edges_seen, 7);
    check("pre_rst_sclk", sclk, 1);
    ARESETn = 1'b0;
    #1;
    check("mid_rst_cs_n", cs_n, 1);
    check("mid_rst_sclk", sclk, 0);
    check("mid_rst_busy", spi_busy, 0);
    check("mid_rst_done", spi_done, 0);
    check("mid_rst_mosi", mosi, 0);
    check("mid_rst_rx", rx_spi, 8'h00);
    void'(exp_q.pop_back());
    last_rx = 8'h00;
    control_reg = 32'h0;
    repeat (2) @(negedge ACLK);

    // Start already high at reset release is taken on the first clock
    start_xfer(2, 1'b0, 1'b0, 8'h69, 8'h00, 1'b1, 1'b0, 1'b1);
    finish_xfer(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_master_core.md
SPI_MASTER_CORE -- requirements
Module: spi_master_core

Interface
REQ-001 Parameter DIV_WIDTH, default 16, width of the half-period counter; only spi_div[DIV_WIDTH-1:0] is used.
REQ-002 ACLK  input  1  system clock; all logic on its rising edge.
REQ-003 ARESETn  input  1  reset, asynchronous, active-low.
REQ-004 control_reg  input  32  AXI control register: [1] SPI_START, [2] SPI_CPOL, [3] SPI_CPHA; other bits ignored.
REQ-005 tx_spi  input  8  byte to transmit.
REQ-006 spi_div  input  32  SCLK half-period in ACLK cycles.
REQ-007 rx_spi  output  8  last received byte.
REQ-008 spi_busy  output  1  transfer in progress.
REQ-009 spi_done  output  1  sticky completion flag; feeds STATUS[2].
REQ-010 sclk  output  1  SPI serial clock.
REQ-011 mosi  output  1  serial data out, MSB first.
REQ-012 miso  input  1  serial data in, MSB first.
REQ-013 cs_n  output  1  active-low chip select.

Function
REQ-014 The block SHALL edge-detect SPI_START with a registered copy: start = control_reg[1] & ~start_q; a level held high SHALL produce one start only.
REQ-015 The FSM SHALL have states IDLE, SHIFT, HOLD.
REQ-016 IDLE + start: latch tx_spi, CPOL, CPHA and D = spi_div[DIV_WIDTH-1:0] (D=0 treated as 1), assert cs_n=0 and spi_busy=1, clear spi_done, enter SHIFT. All four latched values SHALL stay fixed for the transfer.
REQ-017 Start pulses in SHIFT or HOLD SHALL be ignored. Register changes during a transfer SHALL have no effect.
REQ-018 sclk SHALL equal the latched CPOL in IDLE and HOLD.
REQ-019 In SHIFT, the half-period counter SHALL count 0..D-1. At D-1 it SHALL toggle sclk, increment edge count (0..16) and reset to 0.
REQ-020 Edge count SHALL be 4 bits plus terminal detect. Edges 1,3,...,15 are leading; edges 2,4,...,16 are trailing.
REQ-021 CPHA=0: mosi SHALL be driven with bit 7 on the SHIFT entry cycle. miso SHALL be sampled into the shift register on leading edges. mosi SHALL advance on trailing edges 2..14.
REQ-022 CPHA=1: mosi SHALL advance on leading edges, with bit 7 on edge 1. miso SHALL be sampled on trailing edges.
REQ-023 After edge 16, the FSM SHALL enter HOLD for D cycles with cs_n still low.
REQ-024 At the end of HOLD, the block SHALL set cs_n=1, spi_busy=0, spi_done=1 and rx_spi = received byte, and SHALL return to IDLE.
REQ-025 Total latency from the start-detect edge to spi_done=1 SHALL be 17*D+1 ACLK cycles.
REQ-026 rx_spi SHALL change only at transfer completion.
REQ-027 spi_done SHALL stay 1 until the next accepted start.
REQ-028 mosi SHALL be 0 in IDLE.
REQ-029 A start on the same cycle as completion SHALL be ignored; it is accepted on a later cycle only if SPI_START is re-armed (0 then 1).

Reset
REQ-030 On ARESETn low, at any time including mid-transfer, the FSM SHALL go to IDLE with sclk=0, cs_n=1, mosi=0, spi_busy=0, spi_done=0, rx_spi=0x00, start_q=0, and all counters 0.
REQ-031 After reset release, a SPI_START already held at 1 SHALL be detected as a start on the first clock.

Verification
REQ-032 D=2, CPOL=0, CPHA=0, tx=0xA5, miso looped to mosi -> 16 sclk edges at 2-cycle spacing; rx_spi=0xA5; spi_done=1 at cycle 35 after start; cs_n high after.
REQ-033 D=3, CPOL=1, CPHA=1, tx=0x3C, slave model returns 0xC3 -> sclk idles high; mosi bits 0,0,1,1,1,1,0,0; rx_spi=0xC3.
REQ-034 SPI_START held high across two transfer lengths -> exactly one transfer; a 0->1 toggle while busy is ignored and tx changes mid-transfer do not alter mosi.
REQ-035 spi_div=0 -> behaves as D=1; sclk toggles every ACLK cycle; done after 18 cycles.
REQ-036 ARESETn pulsed low after edge 7 -> cs_n=1, sclk=CPOL reset value 0, spi_busy=0, rx_spi=0x00; a new start afterwards completes normally.
